// File: rtl/bus_timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers, four-state counting FSM, registered IRQ.
// Define BUS_TIMER_BE_EN for per-byte writes; otherwise only full-word (BE == 4'b1111) writes are accepted.
//
// state   | meaning
// IDLE    | stopped; waits for En
// LOAD    | copies PRESET into COUNT
// CNT     | decrements COUNT while En stays set
// INT     | terminal count reached; one-shot clears En, auto-reload clears pending
module bus_timer #(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [3:0]  BE,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pending;

    logic        sel;
    logic [1:0]  idx;
    logic        wr_ok;
    logic [31:0] wmask;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic        unused_addr_bits;

    assign sel  = (Addr[31:4] == BASE[31:4]);
    assign idx  = Addr[3:2];
    assign en   = ctrl[0];
    assign mode = ctrl[2:1];
    assign im   = ctrl[3];
    assign unused_addr_bits = ^Addr[1:0];

`ifdef BUS_TIMER_BE_EN
    assign wmask = {{8{BE[3]}}, {8{BE[2]}}, {8{BE[1]}}, {8{BE[0]}}};
    assign wr_ok = sel & WE;
`else
    assign wmask = 32'hFFFF_FFFF;
    assign wr_ok = sel & WE & (BE == 4'b1111);
`endif

    // CTRL lives entirely in byte 0, so only that lane matters for it.
    assign ctrl_wr   = wr_ok & (idx == 2'd0) & wmask[0];
    assign preset_wr = wr_ok & (idx == 2'd1);

    always_comb begin
        DOUT = 32'h0;
        if (sel) begin
            case (idx)
                2'd0:    DOUT = {28'h0, ctrl};
                2'd1:    DOUT = preset;
                2'd2:    DOUT = count;
                default: DOUT = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            ctrl    <= 4'h0;
            preset  <= 32'h0;
            count   <= 32'h0;
            pending <= 1'b0;
            IRQ     <= 1'b0;
        end else begin
            if (preset_wr)
                preset <= (preset & ~wmask) | (DIN & wmask);

            // Placed before the FSM so a terminal-count set in the same cycle wins.
            if (ctrl_wr)
                pending <= 1'b0;

            IRQ <= pending & im;

            case (state)
                ST_IDLE: begin
                    if (en)
                        state <= ST_LOAD;
                end
                ST_LOAD: begin
                    count <= preset;
                    state <= ST_CNT;
                end
                ST_CNT: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (count > 32'd1) begin
                        count <= count - 32'd1;
                    end else begin
                        count   <= 32'h0;
                        pending <= 1'b1;
                        state   <= ST_INT;
                    end
                end
                ST_INT: begin
                    if (mode == 2'd1)
                        pending <= 1'b0;
                    else
                        ctrl[0] <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the FSM so a bus write beats the one-shot En clear.
            if (ctrl_wr)
                ctrl <= DIN[3:0];
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Directed self-checking bench for bus_timer; inputs change and outputs are sampled on the falling edge.
module tb_bus_timer;

    localparam logic [31:0] B      = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = B;
    localparam logic [31:0] A_PRE  = B + 32'd4;
    localparam logic [31:0] A_CNT  = B + 32'd8;
    localparam logic [31:0] A_R3   = B + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Addr = 32'h0;
    logic        WE = 1'b0;
    logic [3:0]  BE = 4'hF;
    logic [31:0] DIN = 32'h0;
    logic [31:0] DOUT;
    logic        IRQ;

    int checks = 0;
    int failures = 0;

    bus_timer #(.BASE(B)) dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .BE   (BE),
        .DIN  (DIN),
        .DOUT (DOUT),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        Addr = a;
        DIN  = d;
        BE   = be;
        WE   = 1'b1;
        @(negedge clk);
        WE  = 1'b0;
        BE  = 4'hF;
        DIN = 32'h0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = DOUT;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(B + 32'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL reset_read idx=%0d got=%h exp=%h", i, d, 32'h0);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        logic [31:0] exp_c;
        bus_write(A_PRE, 32'd5, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rd(A_CNT, d);
            exp_c = (k >= 2 && k <= 6) ? 32'(7 - k) : 32'h0;
            checks++;
            if (d !== exp_c) begin
                failures++;
                $display("FAIL oneshot_count edge=%0d got=%h exp=%h", k, d, exp_c);
            end
            checks++;
            if (IRQ !== (k >= 8)) begin
                failures++;
                $display("FAIL oneshot_irq edge=%0d got=%b exp=%b", k, IRQ, (k >= 8));
            end
        end
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h8) begin
            failures++;
            $display("FAIL oneshot_en_cleared got=%h exp=%h", d, 32'h8);
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        checks++;
        if (IRQ !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_irq_at_clear got=%b exp=1", IRQ);
        end
        @(negedge clk);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_after_clear got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] d;
        logic [31:0] exp_c;
        logic        exp_i;
        int          m;
        bus_write(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            rd(A_CNT, d);
            m = (k - 2) % 8;
            exp_c = (k >= 2 && m <= 4) ? 32'(5 - m) : 32'h0;
            exp_i = (k >= 8) && (k % 8 == 0);
            checks++;
            if (d !== exp_c) begin
                failures++;
                $display("FAIL reload_count edge=%0d got=%h exp=%h", k, d, exp_c);
            end
            checks++;
            if (IRQ !== exp_i) begin
                failures++;
                $display("FAIL reload_irq edge=%0d got=%b exp=%b", k, IRQ, exp_i);
            end
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        @(negedge clk);
    endtask

    task automatic test_midcount();
        logic [31:0] d;
        bus_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd5) begin
            failures++;
            $display("FAIL mid_loaded got=%h exp=%h", d, 32'd5);
        end
        @(negedge clk);
        bus_write(A_CTRL, 32'h0, 4'hF);
        repeat (4) @(negedge clk);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd3) begin
            failures++;
            $display("FAIL mid_frozen got=%h exp=%h", d, 32'd3);
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL mid_irq got=%b exp=0", IRQ);
        end
        bus_write(A_PRE, 32'd7, 4'hF);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd3) begin
            failures++;
            $display("FAIL mid_preset_no_effect got=%h exp=%h", d, 32'd3);
        end
        bus_write(A_CTRL, 32'h1, 4'hF);
        repeat (2) @(negedge clk);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd7) begin
            failures++;
            $display("FAIL mid_reload got=%h exp=%h", d, 32'd7);
        end
        @(negedge clk);
        bus_write(A_CTRL, 32'h0, 4'hF);
        repeat (3) @(negedge clk);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'd5) begin
            failures++;
            $display("FAIL mid_refrozen got=%h exp=%h", d, 32'd5);
        end
    endtask

    task automatic test_preset_zero();
        bus_write(A_PRE, 32'h0, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (IRQ !== (k >= 4)) begin
                failures++;
                $display("FAIL pzero_irq edge=%0d got=%b exp=%b", k, IRQ, (k >= 4));
            end
        end
        bus_write(A_CTRL, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL pzero_irq_cleared got=%b exp=0", IRQ);
        end
    endtask

    task automatic test_byte_enable();
        logic [31:0] d;
        logic [31:0] exp_p;
`ifdef BUS_TIMER_BE_EN
        exp_p = 32'h0000_CC00;
`else
        exp_p = 32'h0;
`endif
        bus_write(A_PRE, 32'h0, 4'hF);
        bus_write(A_PRE, 32'hAABB_CCDD, 4'b0010);
        rd(A_PRE, d);
        checks++;
        if (d !== exp_p) begin
            failures++;
            $display("FAIL be_partial got=%h exp=%h", d, exp_p);
        end
        bus_write(A_PRE, 32'h1234_5678, 4'hF);
        rd(A_PRE, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL be_full got=%h exp=%h", d, 32'h1234_5678);
        end
    endtask

    task automatic test_outside();
        logic [31:0] d;
        bus_write(B + 32'd16, 32'hFFFF_FFFF, 4'hF);
        rd(B + 32'd16, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL out_read got=%h exp=%h", d, 32'h0);
        end
        rd(A_PRE, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            failures++;
            $display("FAIL out_preset got=%h exp=%h", d, 32'h1234_5678);
        end
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL out_ctrl got=%h exp=%h", d, 32'h0);
        end
        bus_write(A_R3, 32'hFFFF_FFFF, 4'hF);
        rd(A_R3, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL idx3_read got=%h exp=%h", d, 32'h0);
        end
        bus_write(A_CNT, 32'hFFFF_FFFF, 4'hF);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL count_readonly got=%h exp=%h", d, 32'h0);
        end
        bus_write(A_CTRL, 32'hFFFF_FFF0, 4'hF);
        rd(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL ctrl_upper_ro got=%h exp=%h", d, 32'h0);
        end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        bus_write(A_PRE, 32'd5, 4'hF);
        bus_write(A_CTRL, 32'h9, 4'hF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(B + 32'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                failures++;
                $display("FAIL midreset_read idx=%0d got=%h exp=%h", i, d, 32'h0);
            end
        end
        checks++;
        if (IRQ !== 1'b0) begin
            failures++;
            $display("FAIL midreset_irq got=%b exp=0", IRQ);
        end
        repeat (6) @(negedge clk);
        rd(A_CNT, d);
        checks++;
        if (d !== 32'h0) begin
            failures++;
            $display("FAIL midreset_stays_idle got=%h exp=%h", d, 32'h0);
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_autoreload();
        test_midcount();
        test_preset_zero();
        test_byte_enable();
        test_outside();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
